clk_enable_gen: RTL and testbench

- Parametrised multi-channel clock-enable generator. It is the successor to the fixed divide-by-9 ripple-flop PPU clock divider.
- Runs entirely in the master clock domain. It produces one-cycle tick strobes and ~50% duty level signals per channel, with no derived clocks.
- Divisors are runtime-programmable and applied glitch-free at period boundaries. A global run/halt input and a sync input phase-align all channels.
- It feeds PPU, CPU and APU logic as clock enables.

---
 rtl/clkgen_pkg.sv | 16 +
 rtl/clk_div_channel.sv | 77 +++++++
 rtl/clk_enable_gen.sv | 64 ++++++
 tb/tb_clk_enable_gen.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clkgen_pkg.sv
// Shared constants and helpers for the clock-enable generator.
package clkgen_pkg;

    localparam int CNT_W_DEFAULT = 8;

    // NES master-clock ratios
    localparam int MASTER_PPU_DIV = 4;
    localparam int MASTER_CPU_DIV = 12;
    localparam int CPU_APU_DIV    = 2;

    // Number of cycles lvl stays high in a period of length d: ceil(d/2)
    function automatic logic [31:0] ceil_half(input logic [31:0] d);
        return (d + 32'd1) >> 1;
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, active divisor, pending divisor and the
// registered tick/lvl outputs.
module clk_div_channel
    import clkgen_pkg::*;
#(
    parameter int               CNT_W    = CNT_W_DEFAULT,
    parameter logic [CNT_W-1:0] DIV_INIT = CNT_W'(1)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             run,
    input  logic             sync,
    input  logic             load_en,
    input  logic [CNT_W-1:0] load_div,
    output logic             tick,
    output logic             lvl,
    output logic             pend
);

    localparam int HW = CNT_W + 1;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] pend_div;
    logic             wrap;
    logic [HW-1:0]    cnt_inc;
    logic [HW-1:0]    half;

    // Wrap decision and the level-clear threshold for the active divisor
    always_comb begin
        wrap    = run && (sync || (cnt == div - CNT_W'(1)));
        cnt_inc = {1'b0, cnt} + HW'(1);
        half    = HW'(ceil_half(32'(div)));
    end

    // Counter, active divisor and tick/lvl outputs
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt  <= '0;
            div  <= DIV_INIT;
            tick <= 1'b0;
            lvl  <= 1'b0;
        end else if (run) begin
            if (wrap) begin
                cnt  <= '0;
                tick <= 1'b1;
                lvl  <= 1'b1;
                if (pend) begin
                    div <= pend_div;
                end
            end else begin
                cnt  <= cnt_inc[CNT_W-1:0];
                tick <= 1'b0;
                if (cnt_inc == half) begin
                    lvl <= 1'b0;
                end
            end
        end else begin
            tick <= 1'b0;
        end
    end

    // Pending divisor: a load on a wrap edge survives to the next wrap,
    // because the wrap consumes the pending state seen before this edge
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pend     <= 1'b0;
            pend_div <= '0;
        end else if (load_en) begin
            pend     <= 1'b1;
            pend_div <= load_div;
        end else if (wrap && pend) begin
            pend <= 1'b0;
        end
    end

endmodule

// File: rtl/clk_enable_gen.sv
// Multi-channel clock-enable generator: write decode, error strobe and
// one clk_div_channel per output.
module clk_enable_gen
    import clkgen_pkg::*;
#(
    parameter int                        NUM_CH      = 2,
    parameter int                        CNT_W       = CNT_W_DEFAULT,
    parameter logic [NUM_CH*CNT_W-1:0]   DIV_DEFAULT = {8'(MASTER_CPU_DIV), 8'(MASTER_PPU_DIV)},
    localparam int                       CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              run_i,
    input  logic              sync_i,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [CNT_W-1:0]  wr_div,
    output logic              wr_err,
    output logic [NUM_CH-1:0] tick_o,
    output logic [NUM_CH-1:0] lvl_o,
    output logic [NUM_CH-1:0] pend_o
);

    logic              wr_bad;
    logic              wr_ok;
    logic [NUM_CH-1:0] load_en;

    // Validate the write and steer it to a single channel
    always_comb begin
        wr_bad  = wr_en && ((wr_div == '0) || (32'(wr_ch) >= 32'(NUM_CH)));
        wr_ok   = wr_en && !wr_bad;
        load_en = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            load_en[i] = wr_ok && (32'(wr_ch) == i);
        end
    end

    // One-cycle error strobe for a rejected write
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_bad;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_div_channel #(
            .CNT_W    (CNT_W),
            .DIV_INIT (DIV_DEFAULT[g*CNT_W +: CNT_W])
        ) u_ch (
            .Clk      (Clk),
            .Reset    (Reset),
            .run      (run_i),
            .sync     (sync_i),
            .load_en  (load_en[g]),
            .load_div (wr_div),
            .tick     (tick_o[g]),
            .lvl      (lvl_o[g]),
            .pend     (pend_o[g])
        );
    end

endmodule

// File: tb/tb_clk_enable_gen.sv
// Self-checking bench for clk_enable_gen: directed vector table, hand-written
// corner sequences and a randomized run against a period-level model.
module tb_clk_enable_gen;

    localparam int NCH = 2;

    logic       Clk = 1'b0;
    logic       Reset, run_i, sync_i, wr_en;
    logic [0:0] wr_ch;
    logic [7:0] wr_div;
    logic       wr_err;
    logic [1:0] tick_o, lvl_o, pend_o;

    logic       wr_en3;
    logic [1:0] wr_ch3;
    logic [7:0] wr_div3;
    logic       wr_err3;
    logic [2:0] tick3, lvl3, pend3;

    always #5 Clk = ~Clk;

    clk_enable_gen #(.NUM_CH(2), .CNT_W(8), .DIV_DEFAULT({8'd12, 8'd4})) u_dut (
        .Clk(Clk), .Reset(Reset), .run_i(run_i), .sync_i(sync_i),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div), .wr_err(wr_err),
        .tick_o(tick_o), .lvl_o(lvl_o), .pend_o(pend_o)
    );

    // Three-channel instance so an out-of-range channel index is expressible
    clk_enable_gen #(.NUM_CH(3), .CNT_W(8), .DIV_DEFAULT({8'd2, 8'd12, 8'd4})) u_dut3 (
        .Clk(Clk), .Reset(Reset), .run_i(run_i), .sync_i(sync_i),
        .wr_en(wr_en3), .wr_ch(wr_ch3), .wr_div(wr_div3), .wr_err(wr_err3),
        .tick_o(tick3), .lvl_o(lvl3), .pend_o(pend3)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: position within the current period, active and
    // pending divisors; lvl is high for the first ceil(div/2) positions.
    int m_div[NCH], m_pos[NCH], m_pdiv[NCH];
    bit m_pend[NCH], m_seen[NCH], m_tick[NCH];
    bit m_err;
    int def_div[NCH] = '{4, 12};

    function automatic void model_edge();
        if (Reset) begin
            for (int c = 0; c < NCH; c++) begin
                m_div[c] = def_div[c]; m_pos[c] = 0; m_pend[c] = 0;
                m_seen[c] = 0; m_tick[c] = 0; m_pdiv[c] = 0;
            end
            m_err = 0;
            return;
        end
        m_err = wr_en && (wr_div == 0 || int'(wr_ch) >= NCH);
        for (int c = 0; c < NCH; c++) begin
            m_tick[c] = 0;
            if (run_i) begin
                if (sync_i || m_pos[c] + 1 == m_div[c]) begin
                    m_pos[c] = 0; m_tick[c] = 1; m_seen[c] = 1;
                    if (m_pend[c]) begin m_div[c] = m_pdiv[c]; m_pend[c] = 0; end
                end else begin
                    m_pos[c]++;
                end
            end
            if (wr_en && !m_err && int'(wr_ch) == c) begin
                m_pdiv[c] = int'(wr_div); m_pend[c] = 1;
            end
        end
    endfunction

    function automatic logic [1:0] m_tick_v();
        logic [1:0] r;
        for (int c = 0; c < NCH; c++) r[c] = m_tick[c];
        return r;
    endfunction

    function automatic logic [1:0] m_lvl_v();
        logic [1:0] r;
        for (int c = 0; c < NCH; c++) r[c] = m_seen[c] && (m_pos[c] < (m_div[c] + 1) / 2);
        return r;
    endfunction

    function automatic logic [1:0] m_pend_v();
        logic [1:0] r;
        for (int c = 0; c < NCH; c++) r[c] = m_pend[c];
        return r;
    endfunction

    task automatic step(input bit cmp);
        @(posedge Clk);
        model_edge();
        #1;
        if (cmp) begin
            chk("model tick", 32'(tick_o), 32'(m_tick_v()));
            chk("model lvl",  32'(lvl_o),  32'(m_lvl_v()));
            chk("model pend", 32'(pend_o), 32'(m_pend_v()));
            chk("model err",  32'(wr_err), 32'(m_err));
        end
    endtask

    task automatic idle_run();
        run_i = 1'b1; sync_i = 1'b0; wr_en = 1'b0;
    endtask

    typedef struct {
        bit       run;
        bit       sync;
        bit       we;
        bit [0:0] ch;
        bit [7:0] dv;
        bit [1:0] t;
        bit [1:0] l;
        bit [1:0] p;
        bit       e;
    } vec_t;

    vec_t vecs[14];
    bit   seen_tick;

    initial begin
        // edges 1..14 from reset with defaults; ch0 rewritten to /3 at edge 6
        vecs[0]  = '{1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0};
        vecs[1]  = '{1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0};
        vecs[2]  = '{1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0};
        vecs[3]  = '{1, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 0};
        vecs[4]  = '{1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 0};
        vecs[5]  = '{1, 0, 1, 0, 3, 2'b00, 2'b00, 2'b01, 0};
        vecs[6]  = '{1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 0};
        vecs[7]  = '{1, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 0};
        vecs[8]  = '{1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 0};
        vecs[9]  = '{1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0};
        vecs[10] = '{1, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 0};
        vecs[11] = '{1, 0, 0, 0, 0, 2'b10, 2'b11, 2'b00, 0};
        vecs[12] = '{1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0};
        vecs[13] = '{1, 0, 0, 0, 0, 2'b01, 2'b11, 2'b00, 0};

        Reset = 1'b1; run_i = 1'b0; sync_i = 1'b0; wr_en = 1'b0;
        wr_ch = '0; wr_div = '0; wr_en3 = 1'b0; wr_ch3 = '0; wr_div3 = '0;
        step(0);
        step(0);
        chk("reset tick", 32'(tick_o), 0);
        chk("reset lvl",  32'(lvl_o),  0);
        chk("reset pend", 32'(pend_o), 0);
        chk("reset err",  32'(wr_err), 0);
        Reset = 1'b0;

        // Directed vector table
        for (int i = 0; i < 14; i++) begin
            run_i = vecs[i].run; sync_i = vecs[i].sync; wr_en = vecs[i].we;
            wr_ch = vecs[i].ch; wr_div = vecs[i].dv;
            step(0);
            chk($sformatf("vec%0d tick", i), 32'(tick_o), 32'(vecs[i].t));
            chk($sformatf("vec%0d lvl", i),  32'(lvl_o),  32'(vecs[i].l));
            chk($sformatf("vec%0d pend", i), 32'(pend_o), 32'(vecs[i].p));
            chk($sformatf("vec%0d err", i),  32'(wr_err), 32'(vecs[i].e));
        end

        // Rejected writes: zero divisor, then out-of-range channel
        idle_run(); wr_en = 1'b1; wr_ch = 1'b0; wr_div = 8'd0;
        step(1);
        chk("zero div err", 32'(wr_err), 1);
        idle_run();
        step(1);
        chk("err one cycle", 32'(wr_err), 0);
        wr_en3 = 1'b1; wr_ch3 = 2'd3; wr_div3 = 8'd5;
        step(1);
        chk("bad ch err", 32'(wr_err3), 1);
        chk("bad ch pend", 32'(pend3), 0);
        wr_ch3 = 2'd2;
        step(1);
        chk("ch2 ok err", 32'(wr_err3), 0);
        chk("ch2 pend", 32'(pend3), 32'(3'b100));
        wr_en3 = 1'b0;

        // Halt for 5 cycles after edge 2, with an ignored sync inside
        Reset = 1'b1; step(1); Reset = 1'b0;
        idle_run(); step(1); step(1);
        run_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sync_i = (i == 2);
            step(1);
            chk("halt tick", 32'(tick_o), 0);
            chk("halt lvl", 32'(lvl_o), 0);
        end
        idle_run();
        step(1);
        chk("resume tick +1", 32'(tick_o[0]), 0);
        step(1);
        chk("resume tick +2", 32'(tick_o[0]), 1);
        for (int i = 0; i < 3; i++) step(1);
        step(1);
        chk("resume tick +6", 32'(tick_o[0]), 1);

        // Sync at edge 7
        Reset = 1'b1; step(1); Reset = 1'b0;
        idle_run();
        for (int i = 1; i <= 6; i++) step(1);
        sync_i = 1'b1;
        step(1);
        chk("sync both tick", 32'(tick_o), 32'(2'b11));
        sync_i = 1'b0;
        for (int i = 8; i <= 10; i++) step(1);
        step(1);
        chk("sync ch0 +4", 32'(tick_o[0]), 1);
        for (int i = 12; i <= 18; i++) step(1);
        step(1);
        chk("sync ch1 +12", 32'(tick_o[1]), 1);

        // Divide-by-1 on ch1, then reset mid-stream
        wr_en = 1'b1; wr_ch = 1'b1; wr_div = 8'd1;
        step(1);
        idle_run();
        seen_tick = 1'b0;
        for (int i = 0; i < 30 && !seen_tick; i++) begin
            step(1);
            seen_tick = tick_o[1];
        end
        chk("ch1 wrap reached", 32'(seen_tick), 1);
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("div1 tick", 32'(tick_o[1]), 1);
            chk("div1 lvl", 32'(lvl_o[1]), 1);
        end
        Reset = 1'b1;
        step(1);
        chk("mid reset tick", 32'(tick_o), 0);
        chk("mid reset lvl", 32'(lvl_o), 0);
        chk("mid reset pend", 32'(pend_o), 0);
        chk("mid reset err", 32'(wr_err), 0);
        Reset = 1'b0;
        for (int i = 1; i <= 11; i++) step(1);
        step(1);
        chk("ch1 back to /12", 32'(tick_o[1]), 1);

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            Reset  = ($urandom_range(0, 149) == 0);
            run_i  = ($urandom_range(0, 9) != 0);
            sync_i = ($urandom_range(0, 24) == 0);
            wr_en  = ($urandom_range(0, 6) == 0);
            wr_ch  = 1'($urandom_range(0, 1));
            wr_div = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 2))
                                                 : 8'($urandom_range(1, 16));
            step(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
